branch_ctrl: RTL
================

# branch_ctrl

Branch/jump controller directly upstream of the program counter. It decodes the branch opcode of the instruction in decode and resolves it against a registered ALU flag register, a programmable jump-target lookup table and a small return-address stack. It drives the PC's `absjump_en`/`target` pair and squashes the one wrong-path instruction that follows every taken jump.

## Interface
- D, 12, program counter / target width
- LUT_W, 5, jump-LUT index width (2^LUT_W entries, D bits each)
- RAS_DEPTH, 4, return-address stack entries
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low: reset==0 at a rising edge clears all state
- prog_ctr  in  D  PC of the instruction currently in decode
- br_op  in  3  000 none, 001 JMP, 010 BEQ (Z), 011 BNE (!Z), 100 BLT (N), 101 CALL, 110 RET, 111 reserved (= none)
- lut_idx  in  LUT_W  LUT entry selecting the target for JMP/Bxx/CALL
- flag_we  in  1  load flag register from alu_zero/alu_neg
- alu_zero, alu_neg  in  1 each  ALU result flags
- lut_we  in  1  LUT write strobe
- lut_waddr  in  LUT_W  LUT write address
- lut_wdata  in  D  LUT write data
- absjump_en  out  1  PC loads target at next edge
- target  out  D  jump destination
- squash  out  1  instruction in decode this cycle is wrong-path; downstream must treat it as a NOP
- ras_overflow  out  1  sticky: CALL pushed onto full stack
- ras_underflow  out  1  sticky: RET with empty stack

## Operation
- State: flag register {Z,N}, LUT (2^LUT_W × D), RAS (RAS_DEPTH × D, circular, with count 0..RAS_DEPTH), squash register, two sticky bits.
- Reset: Z=N=0, all LUT entries 0, RAS count 0, squash=0, both sticky bits 0; absjump_en=0, target=0.
- Taken condition (with squash=0): JMP always; BEQ if Z; BNE if !Z; BLT if N; CALL always; RET if RAS count>0. With squash=1: nothing is taken, and no push, pop, flag load or sticky update occurs. lut_we is still honoured.
- target: LUT[lut_idx] for JMP/Bxx/CALL; RAS top for RET. target=0 whenever absjump_en=0.
- CALL: push (prog_ctr+1) mod 2^D. If the stack is full, the oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow is set and the jump is still taken.
- RET, count>0: pop, count−1. RET, count=0: not taken (falls through), ras_underflow is set, count stays 0.
- Flags: Z/N load at the edge when flag_we=1 and squash=0. A branch in the same cycle as flag_we uses the old flags.
- LUT: write occurs at the edge. A same-cycle read of the address being written returns the old value.
- Squash: the instruction ROM is registered, so the instruction following a taken jump is wrong-path. squash is set for exactly the cycle after any taken jump and is otherwise 0. Because a squashed cycle cannot jump, back-to-back squash is impossible.
- Sticky bits clear only on reset.

## Timing
- absjump_en and target are combinational from br_op, lut_idx and registered state, valid in the same cycle as decode. The PC samples them at the next rising edge.
- Flag, LUT, RAS, squash and sticky updates all occur at the rising edge ending the cycle.
- Latency: taken jump in cycle N → prog_ctr=target in N+1, squash=1 in N+1, first right-path instruction decoded in N+2.
- Reset mid-operation (reset=0 at an edge) overrides everything. Any pending squash, RAS contents and flags are discarded, and a branch that is taken in that cycle has no state side effects.

## Test plan
- Reset/LUT: reset=0 one edge → all outputs 0. Write LUT[3]=0x1A0, then JMP idx 3 → absjump_en=1, target=0x1A0; next cycle squash=1 and a JMP presented there gives absjump_en=0.
- Flags: flag_we=1 with alu_zero=1 and BEQ in the same cycle → not taken (old Z=0). BEQ next cycle → taken. BNE → not taken. alu_neg=1 loaded, then BLT → taken.
- Call/return: prog_ctr=0x010, CALL idx 5 (LUT=0x200) → target 0x200. After the squash cycle, RET → target 0x011, count returns to 0.
- RAS overflow: 5 CALLs from PCs 0x100, 0x110, 0x120, 0x130, 0x140 (squash cycles between them) → ras_overflow=1. 4 RETs → 0x141, 0x131, 0x121, 0x111. A 5th RET → not taken, ras_underflow=1.
- LUT collision: lut_we to idx 7 (0x0FF→0x3C0) in the same cycle as JMP idx 7 → target 0x0FF. The next JMP idx 7 → 0x3C0.
- Reset mid-operation: 2 entries pushed and a taken JMP in progress, reset=0 at that edge → squash=0 and count=0 next cycle. A following RET is not taken and sets ras_underflow.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl
//   Branch/jump resolution for the instruction in decode. Decodes br_op against
//   a registered {Z,N} flag pair, a writable jump-target LUT and a circular
//   return-address stack, drives the PC's absolute-jump request, and marks the
//   single wrong-path instruction that follows every taken jump.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low; clears all state
//   prog_ctr       PC of the instruction in decode
//   br_op          000 none, 001 JMP, 010 BEQ, 011 BNE, 100 BLT, 101 CALL,
//                  110 RET, 111 reserved (treated as none)
//   lut_idx        LUT entry giving the target for JMP/Bxx/CALL
//   flag_we        load Z/N from alu_zero/alu_neg
//   alu_zero       ALU zero flag
//   alu_neg        ALU negative flag
//   lut_we         LUT write strobe
//   lut_waddr      LUT write address
//   lut_wdata      LUT write data
//   absjump_en     PC loads target at the next edge
//   target         jump destination (0 when absjump_en is 0)
//   squash         instruction in decode is wrong-path
//   ras_overflow   sticky: CALL pushed onto a full stack
//   ras_underflow  sticky: RET with an empty stack
module branch_ctrl #(
    parameter int D         = 12,
    parameter int LUT_W     = 5,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [D-1:0]     prog_ctr,
    input  logic [2:0]       br_op,
    input  logic [LUT_W-1:0] lut_idx,
    input  logic             flag_we,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             lut_we,
    input  logic [LUT_W-1:0] lut_waddr,
    input  logic [D-1:0]     lut_wdata,
    output logic             absjump_en,
    output logic [D-1:0]     target,
    output logic             squash,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int LUT_N = 1 << LUT_W;
    localparam int PW    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW    = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_BNE  = 3'b011;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;

    logic          flag_z;
    logic          flag_n;
    logic          squash_q;
    logic          ovf_q;
    logic          unf_q;
    logic [D-1:0]  lut     [LUT_N];
    logic [D-1:0]  ras     [RAS_DEPTH];
    logic [PW-1:0] wr_ptr;      // next free slot; wr_ptr-1 is the top
    logic [CW-1:0] ras_count;

    logic          taken;
    logic          do_push;
    logic          do_pop;
    logic          ret_empty;
    logic [PW-1:0] top_ptr;
    logic [PW-1:0] next_ptr;
    logic          ras_full;

    assign top_ptr  = (wr_ptr == '0) ? PW'(RAS_DEPTH - 1) : wr_ptr - PW'(1);
    assign next_ptr = (wr_ptr == PW'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    assign ras_full = (ras_count == CW'(RAS_DEPTH));

    always_comb begin
        taken = 1'b0;
        case (br_op)
            OP_JMP:  taken = 1'b1;
            OP_BEQ:  taken = flag_z;
            OP_BNE:  taken = !flag_z;
            OP_BLT:  taken = flag_n;
            OP_CALL: taken = 1'b1;
            OP_RET:  taken = (ras_count != '0);
            default: taken = 1'b0;
        endcase
        // A squashed instruction is wrong-path and must not redirect the PC.
        if (squash_q) begin
            taken = 1'b0;
        end
    end

    assign do_push   = taken && (br_op == OP_CALL);
    assign do_pop    = taken && (br_op == OP_RET);
    assign ret_empty = !squash_q && (br_op == OP_RET) && (ras_count == '0);

    always_comb begin
        target = '0;
        if (taken) begin
            target = (br_op == OP_RET) ? ras[top_ptr] : lut[lut_idx];
        end
    end

    assign absjump_en    = taken;
    assign squash        = squash_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            squash_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            wr_ptr    <= '0;
            ras_count <= '0;
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else begin
            // LUT writes are independent of the pipeline and land even in a
            // squashed cycle; the combinational read above sees the old value.
            if (lut_we) begin
                lut[lut_waddr] <= lut_wdata;
            end

            squash_q <= taken;

            if (!squash_q && flag_we) begin
                flag_z <= alu_zero;
                flag_n <= alu_neg;
            end

            if (do_push) begin
                // When full, wr_ptr already points at the oldest entry, so the
                // write overwrites it and the count saturates.
                ras[wr_ptr] <= prog_ctr + D'(1);
                wr_ptr      <= next_ptr;
                if (ras_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    ras_count <= ras_count + CW'(1);
                end
            end else if (do_pop) begin
                wr_ptr    <= top_ptr;
                ras_count <= ras_count - CW'(1);
            end

            if (ret_empty) begin
                unf_q <= 1'b1;
            end
        end
    end

endmodule
